// File: rtl/spi_link_pkg.sv
// Constants and count types for the 4-line SPI pixel link.
// The sender (spi_send_con_2) and this receiver both use this package.
package spi_link_pkg;
    localparam int LINK_LINES      = 4;
    localparam int LINK_DATA_WIDTH = 8;
    localparam int FRAME_H_ACTIVE  = 1280;
    localparam int FRAME_V_ACTIVE  = 720;
    localparam int BEATS_PER_PIXEL = LINK_DATA_WIDTH / LINK_LINES;

    typedef logic [10:0] hcount_t;
    typedef logic [9:0]  vcount_t;
endpackage

// File: rtl/spi_receive_con_sync_chain.sv
// Multi-flop synchroniser for bringing a bus into the local clock domain.
// The clear is asynchronous and active-low, and the value loaded on clear is a parameter.
module sync_chain #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stage <= {DEPTH{RST_VAL}};
        end else begin
            r_stage <= {r_stage[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_stage[DEPTH-1];
endmodule

// File: rtl/spi_receive_con.sv
// SPI pixel-link receiver: synchronises dclk/cs/tlast/cipo, assembles pixels from
// nibble beats, regenerates hcount/vcount and flags frame misalignment.
module spi_receive_con
    import spi_link_pkg::*;
#(
    parameter int DATA_WIDTH  = LINK_DATA_WIDTH,
    parameter int LINES       = LINK_LINES,
    parameter int H_ACTIVE    = FRAME_H_ACTIVE,
    parameter int V_ACTIVE    = FRAME_V_ACTIVE,
    parameter int SYNC_STAGES = 2
)(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  chip_clk_in,
    input  logic [LINES-1:0]      chip_data_in,
    input  logic                  chip_sel_in,
    input  logic                  final_pixel_in,
    output logic [DATA_WIDTH-1:0] pixel_data_out,
    output logic                  pixel_valid_out,
    output logic [10:0]           hcount_out,
    output logic [9:0]            vcount_out,
    output logic                  frame_done_out,
    output logic                  sync_error_out
);
    localparam int BEATS = DATA_WIDTH / LINES;
    localparam int BW    = $clog2(BEATS + 1);
    localparam logic [BW-1:0] BEATS_V = BW'(BEATS);
    localparam hcount_t H_LAST = hcount_t'(H_ACTIVE - 1);
    localparam vcount_t V_LAST = vcount_t'(V_ACTIVE - 1);

    logic             w_dclk_s, w_cs_s, w_last_s;
    logic [LINES-1:0] w_data_s;

    sync_chain #(.WIDTH(1), .DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dclk (
        .i_clk(clk_in), .i_rst_n(rst_in), .i_d(chip_clk_in), .o_q(w_dclk_s));
    sync_chain #(.WIDTH(1), .DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .i_clk(clk_in), .i_rst_n(rst_in), .i_d(chip_sel_in), .o_q(w_cs_s));
    sync_chain #(.WIDTH(1), .DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_last (
        .i_clk(clk_in), .i_rst_n(rst_in), .i_d(final_pixel_in), .o_q(w_last_s));
    sync_chain #(.WIDTH(LINES), .DEPTH(SYNC_STAGES), .RST_VAL('0)) u_sync_data (
        .i_clk(clk_in), .i_rst_n(rst_in), .i_d(chip_data_in), .o_q(w_data_s));

    logic                  r_dclk_d, r_cs_d, r_final;
    logic [BW-1:0]         r_beat_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    hcount_t               r_hcount;
    vcount_t               r_vcount;

    logic w_dclk_rise, w_cs_rise, w_beat, w_emit, w_h_last, w_v_last;

    assign w_dclk_rise = w_dclk_s & ~r_dclk_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;
    assign w_beat      = w_dclk_rise & ~w_cs_s;
    assign w_emit      = (r_beat_cnt == BEATS_V);
    assign w_h_last    = (r_hcount == H_LAST);
    assign w_v_last    = (r_vcount == V_LAST);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_dclk_d        <= 1'b0;
            r_cs_d          <= 1'b1;
            r_final         <= 1'b0;
            r_beat_cnt      <= '0;
            r_shift         <= '0;
            r_hcount        <= '0;
            r_vcount        <= '0;
            pixel_data_out  <= '0;
            pixel_valid_out <= 1'b0;
            hcount_out      <= '0;
            vcount_out      <= '0;
            frame_done_out  <= 1'b0;
            sync_error_out  <= 1'b0;
        end else begin
            r_dclk_d        <= w_dclk_s;
            r_cs_d          <= w_cs_s;
            pixel_valid_out <= 1'b0;
            frame_done_out  <= 1'b0;
            if (w_emit) begin
                pixel_valid_out <= 1'b1;
                pixel_data_out  <= r_shift;
                hcount_out      <= r_hcount;
                vcount_out      <= r_vcount;
                frame_done_out  <= r_final;
                r_beat_cnt      <= '0;
                r_final         <= 1'b0;
                // tlast always realigns to (0,0), even when it arrived early
                if (r_final) begin
                    r_hcount <= '0;
                    r_vcount <= '0;
                    if (!(w_h_last && w_v_last)) sync_error_out <= 1'b1;
                end else if (w_h_last) begin
                    r_hcount <= '0;
                    r_vcount <= w_v_last ? '0 : r_vcount + 10'd1;
                    if (w_v_last) sync_error_out <= 1'b1;
                end else begin
                    r_hcount <= r_hcount + 11'd1;
                end
            end else if (w_beat) begin
                r_shift    <= {r_shift[DATA_WIDTH-LINES-1:0], w_data_s};
                r_beat_cnt <= r_beat_cnt + 1'b1;
                r_final    <= r_final | w_last_s;
            end else if (w_cs_rise && r_beat_cnt != '0) begin
                r_beat_cnt     <= '0;
                r_final        <= 1'b0;
                sync_error_out <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_receive_con.sv
// Randomised bench for spi_receive_con on a reduced 16x8 frame; a pixel-index model
// predicts every strobe, its counts, frame_done and the sticky error flag.
module tb_spi_receive_con;
    localparam int H = 16;
    localparam int V = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dclk = 1'b0;
    logic       cs = 1'b1;
    logic       tlast = 1'b0;
    logic [3:0] cipo = 4'h0;
    logic [7:0] pixel_data_out;
    logic       pixel_valid_out, frame_done_out, sync_error_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;

    always #5 clk = ~clk;

    spi_receive_con #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk_in(clk), .rst_in(rst_n), .chip_clk_in(dclk), .chip_data_in(cipo),
        .chip_sel_in(cs), .final_pixel_in(tlast), .pixel_data_out(pixel_data_out),
        .pixel_valid_out(pixel_valid_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
        .frame_done_out(frame_done_out), .sync_error_out(sync_error_out));

    typedef struct {
        logic [7:0] d;
        int         h;
        int         v;
        logic       done;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0, failures = 0;
    int         cyc = 0, last_rise = 0;
    int         m_idx = 0;
    logic       m_err = 1'b0;
    int         strobes = 0, done_seen = 0;
    logic [7:0] last_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Model: linear pixel index within the frame; tlast forces it back to 0.
    task automatic model_pixel(input logic [7:0] d, input logic last);
        exp_t e;
        e.d = d; e.h = m_idx % H; e.v = m_idx / H; e.done = last;
        exp_q.push_back(e);
        if (last) begin
            if (m_idx != H * V - 1) m_err = 1'b1;
            m_idx = 0;
        end else begin
            if (m_idx == H * V - 1) m_err = 1'b1;
            m_idx = (m_idx + 1) % (H * V);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            last_data = 8'h00;
        end else if (pixel_valid_out) begin
            strobes++;
            if (frame_done_out) done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("data", pixel_data_out, e.d);
                check("hcount", hcount_out, e.h);
                check("vcount", vcount_out, e.v);
                check("frame_done", frame_done_out, e.done);
                check("latency", cyc - last_rise, 4);
                $display("pixel data=%02h h=%0d v=%0d done=%0d", pixel_data_out, hcount_out, vcount_out, frame_done_out);
            end
            last_data = pixel_data_out;
        end else begin
            check("done_without_valid", frame_done_out, 0);
            check("data_hold", pixel_data_out, last_data);
        end
    end

    task automatic send_beat(input logic [3:0] nib, input logic last);
        cipo = nib; tlast = last; dclk = 1'b0;
        repeat (3) @(negedge clk);
        dclk = 1'b1; last_rise = cyc;
        repeat (3) @(negedge clk);
        dclk = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    task automatic send_pixel(input logic [7:0] d, input logic last, input int gap);
        model_pixel(d, last);
        cs = 1'b0;
        send_beat(d[7:4], last);
        send_beat(d[3:0], last);
        repeat (3) @(negedge clk);
        cs = 1'b1; tlast = 1'b0;
        repeat (gap + 2) @(negedge clk);
        drain();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; cs = 1'b1; dclk = 1'b0; tlast = 1'b0;
        @(negedge clk);
        check("rst_valid", pixel_valid_out, 0);
        check("rst_data", pixel_data_out, 0);
        check("rst_hcount", hcount_out, 0);
        check("rst_vcount", vcount_out, 0);
        check("rst_done", frame_done_out, 0);
        check("rst_err", sync_error_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete(); m_idx = 0; m_err = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int s0, d0;
        do_reset();

        // single pixel 0xA5 at (0,0)
        send_pixel(8'hA5, 1'b0, 0);
        check("t1_err", sync_error_out, m_err);

        // full frame, value (h+v), tlast on the last pixel
        do_reset();
        d0 = done_seen;
        for (int i = 0; i < H * V; i++)
            send_pixel(8'((i % H) + (i / H)), (i == H * V - 1), $urandom_range(0, 3));
        check("t2_done_count", done_seen - d0, 1);
        check("t2_err", sync_error_out, 0);

        // truncated frame: tlast at (10,3), then a pixel at (0,0)
        d0 = done_seen;
        for (int i = 0; i <= 3 * H + 10; i++)
            send_pixel(8'($urandom), (i == 3 * H + 10), $urandom_range(0, 2));
        send_pixel(8'($urandom), 1'b0, 0);
        check("t3_done_count", done_seen - d0, 1);
        check("t3_err", sync_error_out, m_err);

        // cs fragment after one beat, then clean 0x3C
        do_reset();
        cs = 1'b0;
        send_beat(4'($urandom), 1'b0);
        repeat (3) @(negedge clk);
        cs = 1'b1;
        m_err = 1'b1;
        repeat (6) @(negedge clk);
        check("t4_err_after_frag", sync_error_out, 1);
        send_pixel(8'h3C, 1'b0, 0);
        check("t4_err", sync_error_out, m_err);

        // reset mid-pixel clears error and stale nibble, then 0x81
        cs = 1'b0;
        send_beat(4'hF, 1'b0);
        do_reset();
        send_pixel(8'h81, 1'b0, 0);
        check("t5_err", sync_error_out, 0);

        // dclk toggling with cs high is ignored
        send_pixel(8'($urandom), 1'b0, 1);
        send_pixel(8'($urandom), 1'b0, 1);
        s0 = strobes;
        for (int i = 0; i < 100; i++) begin
            dclk = ~dclk; cipo = 4'($urandom);
            repeat (3) @(negedge clk);
        end
        dclk = 1'b0;
        repeat (6) @(negedge clk);
        check("t6_strobes", strobes - s0, 0);
        check("t6_hcount", hcount_out, (m_idx - 1) % H);
        check("t6_vcount", vcount_out, (m_idx - 1) / H);
        send_pixel(8'($urandom), 1'b0, 0);

        // random pixels with occasional random tlast
        do_reset();
        for (int i = 0; i < 40; i++)
            send_pixel(8'($urandom), ($urandom_range(0, 15) == 0), $urandom_range(0, 4));
        check("rand_err", sync_error_out, m_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
